// File: rtl/or_sched_pkg.sv
// Shared types and helpers for the round-robin OR scheduler.
package or_sched_pkg;

  typedef enum logic {IDLE, RESP} sched_state_t;

  localparam int unsigned DEF_DATA_W = 8;

  // True when the low `width` bits of value are all ones.
  function automatic logic all_ones(input logic [63:0] value, input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value & mask) == mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Wrap-around priority search: starts after last_grant, or at index 0 when fixed_prio is set.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  input  logic                       fixed_prio,
  output logic [NUM_REQ-1:0]         grant_onehot,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_grant
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  always_comb begin : search
    int unsigned idx;
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    idx          = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = fixed_prio ? k : (32'(last_grant) + 32'd1 + k) % NUM_REQ;
      if (!any_grant && req[idx]) begin
        any_grant         = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/or_unit_rr_sched.sv
// Shares one registered OR datapath among NUM_REQ requesters with a tagged result stream.
// Define OR_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module or_unit_rr_sched
  import or_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic                       sat_evt,
  output logic [CNT_W-1:0]           sat_cnt
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

`ifdef OR_SCHED_FIXED_PRIO_EN
  localparam logic FixedPrio = 1'b1;
`else
  localparam logic FixedPrio = 1'b0;
`endif

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              sat_evt_q, sat_evt_d;
  logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic               grant;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic               sat_now;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req          (req_valid),
    .last_grant   (last_grant_q),
    .fixed_prio   (FixedPrio),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  // No transfer is accepted during reset since its result would be discarded.
  assign grant     = !rst && any_grant && ((state_q == IDLE) || res_ready);
  assign req_ready = grant ? grant_onehot : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_a = sel_a | req_a[i*DATA_W +: DATA_W];
        sel_b = sel_b | req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sat_now = all_ones(64'(sel_a), DATA_W) || all_ones(64'(sel_b), DATA_W);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    sat_evt_d    = 1'b0;
    sat_cnt_d    = sat_cnt_q;
    if (grant) begin
      state_d     = RESP;
      res_valid_d = 1'b1;
      res_data_d  = sel_a | sel_b;
      res_id_d    = grant_idx;
      sat_evt_d   = sat_now;
      if (!FixedPrio) last_grant_d = grant_idx;
      if (sat_now && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + 1'b1;
    end else if (state_q == RESP && res_ready) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
      sat_evt_q    <= 1'b0;
      sat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      sat_evt_q    <= sat_evt_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign sat_evt   = sat_evt_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_or_unit_rr_sched.sv
// Self-checking bench: directed cycle table, reset/fixed-priority sequences, random vs. model.
module tb_or_unit_rr_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [1:0]    res_id;
  logic          sat_evt;
  logic [CW-1:0] sat_cnt;

  or_unit_rr_sched #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .sat_evt   (sat_evt),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: what the result port should show right now.
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_id;
  logic          m_evt;
  int            m_cnt;
  int            m_last;
  int            last_gnt;

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          rdy;
    logic [N-1:0]  e_rdy;
    logic          e_rv;
    logic [DW-1:0] e_data;
    logic [1:0]    e_id;
    logic          e_evt;
    logic [CW-1:0] e_cnt;
  } row_t;

  row_t tbl[27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Grant = the valid requester closest after the last grant (or lowest index in fixed mode).
  function automatic int model_pick(input logic [N-1:0] v, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
`ifdef OR_SCHED_FIXED_PRIO_EN
        d = i;
`else
        d = (i - last - 1 + 2 * N) % N;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [DW-1:0] rnd_byte();
    if ($urandom_range(0, 5) == 0) return 8'hFF;
    return 8'($urandom());
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = '0;
    m_id     = 0;
    m_evt    = 1'b0;
    m_cnt    = 0;
    m_last   = N - 1;
    last_gnt = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic apply(input logic [N-1:0] v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic rdy);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
    end
    res_ready = rdy;
  endtask

  // Compare against the model, advance the model by one clock, then step the DUT.
  task automatic tick();
    int g;
    logic [N-1:0] exp_rdy;
    logic [DW-1:0] ga, gb;
    #1;
    g = (!m_valid || res_ready) ? model_pick(req_valid, m_last) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("sat_evt", 32'(sat_evt), 32'(m_evt));
    chk("sat_cnt", 32'(sat_cnt), 32'(m_cnt));
    if (m_valid) begin
      chk("res_data", 32'(res_data), 32'(m_data));
      chk("res_id", 32'(res_id), 32'(m_id));
    end
    last_gnt = g;
    if (g >= 0) begin
      ga      = req_a[g*DW +: DW];
      gb      = req_b[g*DW +: DW];
      m_valid = 1'b1;
      m_data  = ga | gb;
      m_id    = g;
`ifndef OR_SCHED_FIXED_PRIO_EN
      m_last  = g;
`endif
      m_evt   = (ga == 8'hFF) || (gb == 8'hFF);
      if (m_evt && m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      m_evt = 1'b0;
      if (m_valid && res_ready) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] hold;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    @(posedge clk);
    do_reset();

    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_sat_evt", 32'(sat_evt), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

`ifndef OR_SCHED_FIXED_PRIO_EN
    // Single request, round-robin rotation, backpressure, saturation, regrant of same requester.
    tbl[0]  = '{4'b0001, 8'h0F, 8'hF0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0};
    tbl[1]  = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 8'hFF, 2'd0, 1'b0, 16'd0};
    tbl[2]  = '{4'b1111, 8'h01, 8'h02, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0};
    tbl[3]  = '{4'b1111, 8'h01, 8'h02, 1'b1, 4'b0100, 1'b1, 8'h03, 2'd1, 1'b0, 16'd0};
    tbl[4]  = '{4'b1111, 8'h01, 8'h02, 1'b1, 4'b1000, 1'b1, 8'h03, 2'd2, 1'b0, 16'd0};
    tbl[5]  = '{4'b1111, 8'h01, 8'h02, 1'b1, 4'b0001, 1'b1, 8'h03, 2'd3, 1'b0, 16'd0};
    tbl[6]  = '{4'b1111, 8'h01, 8'h02, 1'b1, 4'b0010, 1'b1, 8'h03, 2'd0, 1'b0, 16'd0};
    tbl[7]  = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 8'h03, 2'd1, 1'b0, 16'd0};
    tbl[8]  = '{4'b0001, 8'h11, 8'h22, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0};
    tbl[9]  = '{4'b0100, 8'h11, 8'h22, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd0, 1'b0, 16'd0};
    tbl[10] = '{4'b0100, 8'h11, 8'h22, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd0, 1'b0, 16'd0};
    tbl[11] = '{4'b0100, 8'h11, 8'h22, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd0, 1'b0, 16'd0};
    tbl[12] = '{4'b0100, 8'h11, 8'h22, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd0, 1'b0, 16'd0};
    tbl[13] = '{4'b0000, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b0, 16'd0};
    tbl[14] = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b0, 16'd0};
    tbl[15] = '{4'b0001, 8'hFF, 8'h00, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0, 16'd0};
    tbl[16] = '{4'b0000, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1, 8'hFF, 2'd0, 1'b1, 16'd1};
    tbl[17] = '{4'b0000, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1, 8'hFF, 2'd0, 1'b0, 16'd1};
    tbl[18] = '{4'b0000, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1, 8'hFF, 2'd0, 1'b0, 16'd1};
    tbl[19] = '{4'b0000, 8'h00, 8'h00, 1'b0, 4'b0000, 1'b1, 8'hFF, 2'd0, 1'b0, 16'd1};
    tbl[20] = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 8'hFF, 2'd0, 1'b0, 16'd1};
    tbl[21] = '{4'b0010, 8'h7F, 8'h80, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0, 16'd1};
    tbl[22] = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 8'hFF, 2'd1, 1'b0, 16'd1};
    tbl[23] = '{4'b0010, 8'h01, 8'h00, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0, 16'd1};
    tbl[24] = '{4'b0010, 8'h01, 8'h00, 1'b1, 4'b0010, 1'b1, 8'h01, 2'd1, 1'b0, 16'd1};
    tbl[25] = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1, 8'h01, 2'd1, 1'b0, 16'd1};
    tbl[26] = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 16'd1};

    for (int r = 0; r < 27; r++) begin
      apply(tbl[r].v, tbl[r].a, tbl[r].b, tbl[r].rdy);
      #1;
      chk($sformatf("tbl%0d_req_ready", r), 32'(req_ready), 32'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_res_valid", r), 32'(res_valid), 32'(tbl[r].e_rv));
      chk($sformatf("tbl%0d_sat_evt", r), 32'(sat_evt), 32'(tbl[r].e_evt));
      chk($sformatf("tbl%0d_sat_cnt", r), 32'(sat_cnt), 32'(tbl[r].e_cnt));
      if (tbl[r].e_rv) begin
        chk($sformatf("tbl%0d_res_data", r), 32'(res_data), 32'(tbl[r].e_data));
        chk($sformatf("tbl%0d_res_id", r), 32'(res_id), 32'(tbl[r].e_id));
      end
      tick();
    end
`else
    // Fixed priority: requester 1 wins every cycle until it drops, then 3.
    for (int r = 0; r < 4; r++) begin
      apply(4'b1010, 8'h01, 8'h10, 1'b1);
      #1;
      chk("fixed_req_ready_1", 32'(req_ready), 32'b0010);
      tick();
    end
    apply(4'b1000, 8'h01, 8'h10, 1'b1);
    #1;
    chk("fixed_req_ready_3", 32'(req_ready), 32'b1000);
    tick();
    apply(4'b0000, 8'h00, 8'h00, 1'b1);
    tick();
    tick();
`endif

    // Reset while a saturating result is pending.
    apply(4'b0100, 8'hFF, 8'h00, 1'b0);
    tick();
    apply(4'b0000, 8'h00, 8'h00, 1'b0);
    tick();
    do_reset();
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("midrst_sat_evt", 32'(sat_evt), 32'd0);
    apply(4'b1001, 8'h0A, 8'h50, 1'b1);
    #1;
    chk("midrst_first_grant", 32'(req_ready), 32'b0001);
    tick();
    apply(4'b0000, 8'h00, 8'h00, 1'b1);
    tick();
    tick();

    // Random traffic; a requester keeps valid and operands stable until granted.
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req_valid[i]      = 1'($urandom_range(0, 1));
          req_a[i*DW +: DW] = rnd_byte();
          req_b[i*DW +: DW] = rnd_byte();
        end
      end
      res_ready = ($urandom_range(0, 9) < 7);
      hold = req_valid;
      tick();
      if (last_gnt >= 0) hold[last_gnt] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
